// File: rtl/credit_source_injector.sv
// Packet-to-flit injector for one network input channel.
// Buffers host packets and drives flits under credit flow control.
module credit_source_injector #(
  parameter int FLIT_WIDTH   = 32,
  parameter int PACKET_FLITS = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int BUFFER_DEPTH = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [PACKET_FLITS*FLIT_WIDTH-1:0] packet_din,
  input  logic                               packet_valid_din,
  output logic                               packet_ready_dout,
  output logic [FLIT_WIDTH:0]                channel_dout,
  input  logic                               credit_in_din,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0]  credits_available_dout,
  output logic [CNT_WIDTH-1:0]               packets_sent_dout,
  output logic                               busy_dout,
  output logic                               credit_overflow_dout
);

  localparam int PW = PACKET_FLITS * FLIT_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(PACKET_FLITS);
  localparam int CW = $clog2(BUFFER_DEPTH + 1);
  localparam logic [CW-1:0] CMAX  = CW'(BUFFER_DEPTH);
  localparam logic [IW-1:0] ILAST = IW'(PACKET_FLITS - 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         mem_q [FIFO_DEPTH];
  logic [AW:0]           wr_q, wr_d;
  logic [AW:0]           rd_q, rd_d;
  logic [FLIT_WIDTH-1:0] pkt_q [PACKET_FLITS];
  logic [FLIT_WIDTH-1:0] pkt_d [PACKET_FLITS];
  logic [IW-1:0]         idx_q, idx_d;
  logic [FLIT_WIDTH:0]   chan_q, chan_d;
  logic [CW-1:0]         cred_q, cred_d;
  logic [CNT_WIDTH-1:0]  sent_q, sent_d;
  logic                  ovf_q, ovf_d;

  logic          empty, full;
  logic          push, pop, send, last;
  logic [PW-1:0] head;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    push    = packet_valid_din && !full;
    send    = (state_q == SEND) && (cred_q != '0);
    last    = (idx_q == ILAST);
    pop     = !empty && ((state_q == IDLE) || (send && last));
    state_d = state_q;
    idx_d   = idx_q;
    pkt_d   = pkt_q;
    chan_d  = '0;
    sent_d  = sent_q;
    ovf_d   = ovf_q;
    cred_d  = cred_q;
    wr_d    = wr_q + (AW+1)'(push);
    rd_d    = rd_q + (AW+1)'(pop);
    if (send) begin
      chan_d = {1'b1, pkt_q[idx_q]};
      idx_d  = idx_q + 1'b1;
    end
    if (send && last) begin
      sent_d  = sent_q + 1'b1;
      state_d = IDLE;
    end
    // Popping on the last flit chains packets without a bubble
    if (pop) begin
      for (int i = 0; i < PACKET_FLITS; i++)
        pkt_d[i] = head[(PACKET_FLITS-1-i)*FLIT_WIDTH +: FLIT_WIDTH];
      idx_d   = '0;
      state_d = SEND;
    end
    if (credit_in_din && !send && (cred_q == CMAX))
      ovf_d = 1'b1;
    else
      cred_d = cred_q - CW'(send) + CW'(credit_in_din);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      pkt_q   <= '{default: '0};
      idx_q   <= '0;
      chan_q  <= '0;
      cred_q  <= CMAX;
      sent_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      pkt_q   <= pkt_d;
      idx_q   <= idx_d;
      chan_q  <= chan_d;
      cred_q  <= cred_d;
      sent_q  <= sent_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_q[AW-1:0]] <= packet_din;
  end

  assign packet_ready_dout      = !full;
  assign channel_dout           = chan_q;
  assign credits_available_dout = cred_q;
  assign packets_sent_dout      = sent_q;
  assign busy_dout              = !empty || (state_q != IDLE);
  assign credit_overflow_dout   = ovf_q;

endmodule

// File: doc/credit_source_injector.md
Name: credit_source_injector

Overview:
- Source-side injection stage that feeds one Y-port input channel of the deflector-wrapped test-engine network core.
- Accepts whole packets from the test host on a valid/ready interface and buffers them in a small FIFO.
- Serialises each packet into flits and drives them onto the network channel under credit-based flow control.
- Tracks downstream buffer credits returned by the core. One instance is placed per ypos/yneg channel.

Parameters:
- FLIT_WIDTH, 32, payload bits per flit. The channel word is FLIT_WIDTH+1 bits wide.
- PACKET_FLITS, 4, flits per packet. Legal range is 2 to 16.
- FIFO_DEPTH, 4, packets held in the input FIFO. Must be a power of 2, at least 2.
- BUFFER_DEPTH, 4, downstream input-buffer slots. This is the initial and maximum credit count.
- CNT_WIDTH, 16, width of the sent-packet counter.

Ports:
- clk  in  1  system clock. All logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- packet_din  in  PACKET_FLITS*FLIT_WIDTH  host packet. Flit 0 occupies the most-significant FLIT_WIDTH bits.
- packet_valid_din  in  1  host packet valid.
- packet_ready_dout  out  1  high when the FIFO can accept a packet.
- channel_dout  out  FLIT_WIDTH+1  network channel. The MSB is the valid flag; the low FLIT_WIDTH bits are the flit.
- credit_in_din  in  1  one-cycle pulse from the core. Each pulse returns one buffer slot.
- credits_available_dout  out  clog2(BUFFER_DEPTH+1)  current credit count.
- packets_sent_dout  out  CNT_WIDTH  number of packets whose last flit has been sent.
- busy_dout  out  1  high when the FIFO is non-empty or the state is not IDLE.
- credit_overflow_dout  out  1  sticky error flag. Set when a credit arrives while the count is already at BUFFER_DEPTH.

Behaviour:
- Reset values:
  - FIFO is empty and packet_ready_dout=1.
  - channel_dout=0, i.e. invalid with zero data.
  - credits=BUFFER_DEPTH.
  - packets_sent_dout=0, credit_overflow_dout=0, busy_dout=0.
  - FSM is in IDLE with the flit index at 0.
- Reset mid-packet discards the in-flight packet and all FIFO contents. No partial flits are driven after reset.
- Host handshake:
  - A transfer occurs when packet_valid_din and packet_ready_dout are both high at a rising edge.
  - packet_ready_dout is !full, decoded from registered FIFO state. It does not depend combinationally on packet_valid_din.
  - A push and a pop in the same cycle while full is not permitted, because ready is low. A push and a pop while non-full leaves the occupancy unchanged.
- FSM states IDLE, SEND:
  - IDLE with the FIFO non-empty: pop the head into the packet register, clear the flit index, and go to SEND.
  - SEND with credits>0: register channel_dout = {1, flit[index]} and decrement the credits.
    - If index = PACKET_FLITS-1, packets_sent increments (wrapping modulo 2^CNT_WIDTH).
    - On that last flit, if the FIFO is non-empty, pop the next packet in the same cycle, reset the index to 0 and stay in SEND. There is no bubble between packets.
    - On that last flit with the FIFO empty, go to IDLE.
    - Otherwise the index increments.
  - SEND with credits=0: the FSM stalls and channel_dout = 0 for that cycle. The flit is held and the index is unchanged.
  - In every cycle in which no flit is sent, channel_dout = 0. Valid is never held across cycles.
- Latency: a packet accepted at edge t is in the FIFO at t+1, popped in IDLE, and in SEND at t+2. Flit 0 appears on channel_dout during the cycle after edge t+2 (i.e. 3 edges after acceptance), provided credits>0.
- Credit arithmetic: next = credits - send + credit_in_din.
  - A send and a returned credit in the same cycle leave the count unchanged.
  - A credit arriving at BUFFER_DEPTH with no send: the count saturates at BUFFER_DEPTH and credit_overflow_dout is set. It stays set until reset.
  - The count never underflows, because a send requires credits>0.
- Throughput: one flit per cycle while credits are available, with continuous back-to-back packets.

Test Plan:
- Reset then push one packet {A0,A1,A2,A3} (defaults), with credit_in tied 0 except as noted:
  - Channel valid flits A0..A3 appear on 4 consecutive cycles, starting the cycle after the third edge from acceptance.
  - credits go 4→0 and packets_sent=1.
- Push 2 packets, with no credit returns:
  - 4 flits of packet 1 are sent, then the channel stays invalid. busy=1 and credits=0.
  - Pulse credit_in once: exactly one flit, B0, is emitted one cycle later. credits returns to 0.
- Push 5 packets back-to-back while the FSM is stalled at credits=0:
  - packet_ready drops after the FIFO fills (4 held); the fifth transfer is held off until a pop.
  - Return credits every cycle: all 20 flits arrive in order with no inter-packet bubble. packets_sent=5.
- Simultaneous send and credit return every cycle for 12 cycles:
  - credits stay constant at the start value of 4.
  - credit_overflow remains 0.
- At idle with credits=4, pulse credit_in:
  - credits stay 4 and credit_overflow=1. It stays 1 until reset.
- Assert reset on the cycle after flit 1 of a packet:
  - channel_dout=0 from the next cycle, FIFO empty, credits=4, packets_sent=0.
  - No further flits of the discarded packet appear.
